// File: rtl/mem_fill_responder.sv
// mem_fill_responder: fixed-latency word storage responder for cache fill requests
module mem_fill_responder #(
    parameter int LATENCY = 4,
    parameter int MEM_AW  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] data_addr,
    output logic [3:0]  pending,
    output logic        busy
);
    logic [15:0]        mem [2**MEM_AW];
    logic [LATENCY-1:0] pv;
    logic [15:0]        pa [LATENCY];
    logic [15:0]        pd [LATENCY];
    logic [MEM_AW-1:0]  idx;
    logic               rd;

    assign idx        = addr[MEM_AW:1];
    assign rd         = enable && !wr;
    assign data_valid = pv[LATENCY-1];
    assign data_out   = pd[LATENCY-1];
    assign data_addr  = pa[LATENCY-1];
    assign busy       = pending != 4'd0;

    // Storage writes; deliberately unreset so contents survive rst_n
    always_ff @(posedge clk)
        if (rst_n && enable && wr) mem[idx] <= data_in;

    // Read pipeline: stage 0 samples storage at the issue edge; a stage only takes new data when valid so outputs hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pa[i] <= '0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= rd;
            pa[0] <= rd ? (addr & 16'hFFFE) : pa[0];
            pd[0] <= rd ? mem[idx] : pd[0];
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pv[i-1] ? pa[i-1] : pa[i];
                pd[i] <= pv[i-1] ? pd[i-1] : pd[i];
            end
        end
    end

    // Outstanding reads: counted at issue, retired on the edge after their data_valid cycle
    always_ff @(posedge clk) begin
        if (!rst_n) pending <= '0;
        else pending <= pending + 4'(rd) - 4'(data_valid);
    end
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: randomized and directed checks of mem_fill_responder at LATENCY 4 and 1
module tb_mem_fill_responder;
    logic        clk = 1'b0;
    logic        rst_n, enable, wr;
    logic [15:0] addr, data_in;
    logic [15:0] do4, da4, do1, da1;
    logic        dv4, bz4, dv1, bz1;
    logic [3:0]  pe4, pe1;
    logic [37:0] got4, got1, x4, x1;

    int          cmp = 0;
    int          err = 0;
    int          e = 0;
    int          last_rst = 0;
    bit          rd_v [4096];
    logic [15:0] rd_a [4096];
    logic [15:0] rd_d [4096];
    logic [15:0] mem_m [32768];
    logic [15:0] hd [2];
    logic [15:0] ha [2];

    always #5 clk = ~clk;

    mem_fill_responder #(.LATENCY(4), .MEM_AW(15)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(do4), .data_valid(dv4), .data_addr(da4), .pending(pe4), .busy(bz4)
    );

    mem_fill_responder #(.LATENCY(1), .MEM_AW(15)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(do1), .data_valid(dv1), .data_addr(da1), .pending(pe1), .busy(bz1)
    );

    assign got4 = {dv4, do4, da4, pe4, bz4};
    assign got1 = {dv1, do1, da1, pe1, bz1};

    // Reference: a read issued at edge s shows after edge s+L-1; pending counts reads issued in the last L edges since reset
    task automatic calc(input int lat, input int j, output logic [37:0] x);
        int  s;
        int  p;
        int  k0;
        logic v;
        s = e - lat + 1;
        p = 0;
        v = (s > last_rst) && (s > 0) && rd_v[s];
        if (v) begin
            hd[j] = rd_d[s];
            ha[j] = rd_a[s];
        end
        k0 = (s > last_rst) ? s : last_rst + 1;
        for (int k = k0; k <= e; k++) p += int'(rd_v[k]);
        x = {v, hd[j], ha[j], 4'(p), p != 0};
    endtask

    task automatic tick(input logic rn, input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        rst_n = rn; enable = en; wr = w; addr = a; data_in = d;
        @(posedge clk);
        e++;
        rd_v[e] = 1'b0;
        if (!rn) begin
            last_rst = e;
            hd[0] = '0; hd[1] = '0; ha[0] = '0; ha[1] = '0;
        end else begin
            rd_v[e] = en && !w;
            if (rd_v[e]) begin
                rd_a[e] = {a[15:1], 1'b0};
                rd_d[e] = mem_m[a[15:1]];
            end
            if (en && w) mem_m[a[15:1]] = d;
        end
        calc(4, 0, x4);
        calc(1, 1, x1);
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 16'h0, 16'h0);
        cmp++;
        if (got4 !== 38'h0) begin err++; $display("FAIL reset_l4: got %h expected 0", got4); end
        cmp++;
        if (got1 !== 38'h0) begin err++; $display("FAIL reset_l1: got %h expected 0", got1); end
        tick(1, 1, 1, 16'h0100, 16'h1234);
        tick(0, 1, 1, 16'h0100, 16'hDEAD);
        tick(1, 1, 0, 16'h0100, 16'h0);
        for (int i = 0; i < 5; i++) begin
            if (dv4) begin
                cmp++;
                if (do4 !== 16'h1234) begin err++; $display("FAIL reset_drop_write: got %h expected 1234", do4); end
            end
            tick(1, 0, 0, 16'h0, 16'h0);
        end
    endtask

    task automatic test_burst();
        int peak4 = 0;
        int peak1 = 0;
        int nv = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 8) tick(1, 1, 1, 16'(16'h0010 + 2*i), 16'(16'h1111 * (i + 1)));
            else if (i < 16) tick(1, 1, 0, 16'(16'h0010 + 2*(i - 8)), 16'h0);
            else tick(1, 0, 0, 16'h0, 16'h0);
            if (int'(pe4) > peak4) peak4 = int'(pe4);
            if (int'(pe1) > peak1) peak1 = int'(pe1);
            if (dv4) nv++;
            cmp++;
            if (got4 !== x4) begin err++; $display("FAIL burst_l4 edge %0d: got %h expected %h", e, got4, x4); end
            cmp++;
            if (got1 !== x1) begin err++; $display("FAIL burst_l1 edge %0d: got %h expected %h", e, got1, x1); end
        end
        cmp++;
        if (peak4 != 4 || nv != 8 || pe4 !== 4'd0) begin
            err++; $display("FAIL burst_peak: peak %0d valids %0d final %0d expected 4 8 0", peak4, nv, pe4);
        end
        cmp++;
        if (peak1 != 1) begin err++; $display("FAIL l1_peak: got %0d expected 1", peak1); end
    endtask

    task automatic test_read_then_write();
        logic [15:0] seen [$];
        tick(1, 1, 1, 16'h0040, 16'hAAAA);
        tick(1, 1, 0, 16'h0040, 16'h0);
        tick(1, 1, 1, 16'h0040, 16'h5555);
        tick(1, 0, 0, 16'h0, 16'h0);
        tick(1, 1, 0, 16'h0040, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (dv4) seen.push_back(do4);
            cmp++;
            if (got4 !== x4) begin err++; $display("FAIL rw_l4 edge %0d: got %h expected %h", e, got4, x4); end
            cmp++;
            if (got1 !== x1) begin err++; $display("FAIL rw_l1 edge %0d: got %h expected %h", e, got1, x1); end
            tick(1, 0, 0, 16'h0, 16'h0);
        end
        cmp++;
        if (seen.size() != 2 || seen[0] !== 16'hAAAA || seen[1] !== 16'h5555) begin
            err++; $display("FAIL rw_order: got %0d words expected AAAA then 5555", seen.size());
        end
    endtask

    task automatic test_alternate();
        string pat = "";
        tick(1, 1, 1, 16'h0002, 16'h0202);
        tick(1, 1, 1, 16'h0004, 16'h0404);
        for (int i = 0; i < 9; i++) begin
            if (i == 0) tick(1, 1, 0, 16'h0002, 16'h0);
            else if (i == 1) tick(1, 1, 1, 16'h0004, 16'h4444);
            else if (i == 2) tick(1, 1, 0, 16'h0004, 16'h0);
            else tick(1, 0, 0, 16'h0, 16'h0);
            if (i >= 3 && i <= 5) pat = {pat, dv4 ? "1" : "0"};
            cmp++;
            if (got4 !== x4) begin err++; $display("FAIL alt_l4 edge %0d: got %h expected %h", e, got4, x4); end
            cmp++;
            if (got1 !== x1) begin err++; $display("FAIL alt_l1 edge %0d: got %h expected %h", e, got1, x1); end
        end
        cmp++;
        if (pat != "101") begin err++; $display("FAIL alt_pattern: got %s expected 101", pat); end
    endtask

    task automatic test_odd_addr();
        tick(1, 1, 0, 16'h0013, 16'h0);
        for (int i = 0; i < 4; i++) begin
            if (dv4) begin
                cmp++;
                if (do4 !== 16'h2222 || da4 !== 16'h0012) begin
                    err++; $display("FAIL odd_addr: got %h@%h expected 2222@0012", do4, da4);
                end
            end
            tick(1, 0, 0, 16'h0, 16'h0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int nv = 0;
        tick(1, 1, 0, 16'h0010, 16'h0);
        tick(1, 1, 0, 16'h0012, 16'h0);
        tick(0, 1, 0, 16'h0014, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (dv4 || dv1) nv++;
            cmp++;
            if (got4 !== x4) begin err++; $display("FAIL midrst_l4 edge %0d: got %h expected %h", e, got4, x4); end
            tick(1, 0, 0, 16'h0, 16'h0);
        end
        cmp++;
        if (nv != 0 || pe4 !== 4'd0 || bz4 !== 1'b0) begin
            err++; $display("FAIL midrst_flush: valids %0d pending %0d busy %0d expected 0 0 0", nv, pe4, bz4);
        end
        for (int i = 0; i < 14; i++) begin
            if (i < 8) tick(1, 1, 0, 16'(16'h0010 + 2*i), 16'h0);
            else tick(1, 0, 0, 16'h0, 16'h0);
            cmp++;
            if (got4 !== x4) begin err++; $display("FAIL midrst_rd_l4 edge %0d: got %h expected %h", e, got4, x4); end
            cmp++;
            if (got1 !== x1) begin err++; $display("FAIL midrst_rd_l1 edge %0d: got %h expected %h", e, got1, x1); end
        end
    endtask

    task automatic test_random();
        int op;
        logic [15:0] a;
        for (int i = 0; i < 32; i++) tick(1, 1, 1, 16'(2*i), 16'($urandom));
        tick(1, 1, 1, 16'hFFFE, 16'($urandom));
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 39));
            a = ($urandom_range(0, 9) == 0) ? {15'h7FFF, 1'($urandom)} : 16'($urandom_range(0, 63));
            if (op == 0) tick(0, 1'($urandom), 1'($urandom), a, 16'($urandom));
            else if (op < 10) tick(1, 0, 1'($urandom), a, 16'($urandom));
            else if (op < 20) tick(1, 1, 1, a, 16'($urandom));
            else tick(1, 1, 0, a, 16'h0);
            cmp++;
            if (got4 !== x4) begin err++; $display("FAIL rand_l4 edge %0d: got %h expected %h", e, got4, x4); end
            cmp++;
            if (got1 !== x1) begin err++; $display("FAIL rand_l1 edge %0d: got %h expected %h", e, got1, x1); end
        end
    endtask

    initial begin
        hd[0] = '0; hd[1] = '0; ha[0] = '0; ha[1] = '0;
        test_reset();
        test_burst();
        test_read_then_write();
        test_alternate();
        test_odd_addr();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
